conv_rd_sched: RTL and testbench
================================

Name: conv_rd_sched

Overview:
- Read-request sequencer for the conv input path.
- Accepts one fetch command at a time and holds the mux configuration word `info` stable for the whole transfer.
- Emits the matching address stream (first/last-tagged, valid/ready) toward the ram/sdram address mux.
- Observes the mux output data handshake and retires the command only when the final data beat has been consumed, then pulses `done`.

Parameters:
- AW, 13, address width; addresses wrap modulo 2^AW.
- LW, 13, beat-count width; `cmd_len` encodes beats-1.
- IFW, 5, info width; fixed layout {ram_sel, mem_sel, channel[2:0]}. Other values unsupported.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_base  in  AW  start address.
- cmd_len  in  LW  number of beats minus 1.
- cmd_ram_sel  in  1  target ram bank select.
- cmd_mem_sel  in  1  0 = on-chip ram, 1 = sdram picture.
- cmd_channel  in  3  active channel count; 0 means all 8.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when valid&ready.
- info  out  IFW  {ram_sel, mem_sel, channel} for the mux.
- m_addr  out  AW  current address.
- m_addr_first  out  1  first address beat.
- m_addr_last  out  1  last address beat.
- m_addr_valid  out  1  address valid.
- m_addr_ready  in  1  address ready.
- s_data_valid  in  1  mux output valid (monitor only).
- s_data_ready  in  1  mux output ready (monitor only).
- s_data_last  in  1  mux output last (monitor only).
- busy  out  1  command in flight.
- done  out  1  one-cycle pulse at retirement.
- err  out  1  sticky beat-count mismatch.

Behaviour:
- Reset values:
  - state=IDLE, info=0, m_addr=0, m_addr_valid=0, m_addr_first=0, m_addr_last=0.
  - busy=0, done=0, err=0, internal counters=0.
- cmd_ready = (state==IDLE), combinational from state. It is 1 from the first cycle after reset release.
- FSM states:
  - IDLE:
    - On cmd_valid&cmd_ready, latch base, len and info fields; clear addr_cnt, beat_cnt, last_seen and err.
    - Next state is ADDR. m_addr_valid rises the cycle after acceptance (latency 1).
  - ADDR:
    - m_addr_valid=1; m_addr = cmd_base + addr_cnt, truncated to AW bits (wrap).
    - m_addr_first = (addr_cnt==0); m_addr_last = (addr_cnt==len).
    - Each m_addr_valid&m_addr_ready increments addr_cnt.
    - Handshake with m_addr_last=1 moves to DRAIN; m_addr_valid deasserts the next cycle.
    - Outputs hold stable while valid&!ready.
  - DRAIN:
    - m_addr_valid=0.
    - Wait for a data beat with s_data_valid&s_data_ready&s_data_last, or last_seen already set.
    - Then next state is IDLE and done=1 for exactly one cycle, coincident with the first IDLE cycle.
- Data monitor:
  - Active in ADDR and DRAIN.
  - Each s_data_valid&s_data_ready increments beat_cnt; a beat with last sets last_seen.
  - If last arrives while in ADDR, last_seen is recorded; DRAIN then exits on its first cycle.
  - On the last beat, if beat_cnt (pre-increment) != len, set err. err stays set until the next command acceptance.
  - Beats in IDLE are ignored.
- info:
  - Updated only on command acceptance; held constant through ADDR and DRAIN and into IDLE until the next accept.
  - cmd_channel is passed through unchanged; 0 means 8 channels.
- busy = (state != IDLE).
- Single-beat command (cmd_len=0): one address with first=last=1.
- Back-to-back commands: a new command can be accepted in the same cycle done is high, since that is an IDLE cycle.
- Reset asserted mid-operation: all state returns to reset values immediately; a partial burst is abandoned and no done is issued.

Test Plan:
- Single burst: cmd_base=0x010, cmd_len=3, mem_sel=0, channel=0, m_addr_ready=1, 4 data beats with last on the 4th.
  - Required: addresses 0x010..0x013; first on 0x010, last on 0x013; info=5'b00000 throughout.
  - Required: done pulse 1 cycle after the last data beat; err=0.
- Backpressure: m_addr_ready toggling 1,0,0,1,...
  - Required: m_addr, m_addr_first and m_addr_last stable while stalled; exactly len+1 handshakes; no duplicated or skipped address.
- Wrap: cmd_base=0x1FFE, cmd_len=3.
  - Required: addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- Early last: s_data_last handshaked while still in ADDR (len=1, address ready delayed).
  - Required: DRAIN lasts 1 cycle, then done.
- Count mismatch: cmd_len=3 with last on the 2nd data beat.
  - Required: err=1 and done still pulses; err stays set; err clears on the next cmd accept.
- Reset mid-burst: rst_n low during ADDR after 2 beats.
  - Required: m_addr_valid=0, busy=0, info=0 immediately; after release, cmd_ready=1 and no done pulse is produced.

Source files
------------

// File: rtl/conv_rd_sched_if.sv
// conv_rd_sched_if: command, address-stream, data-monitor and status bundle for conv_rd_sched
//   slave  : sequencer side (takes cmd_*, drives info/m_addr*/busy/done/err, watches s_data_*)
//   master : controller/mux side (the reverse directions)
interface conv_rd_sched_if #(
  parameter int AW  = 13,
  parameter int LW  = 13,
  parameter int IFW = 5
);
  logic [AW-1:0]  cmd_base;
  logic [LW-1:0]  cmd_len;
  logic           cmd_ram_sel;
  logic           cmd_mem_sel;
  logic [2:0]     cmd_channel;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [IFW-1:0] info;
  logic [AW-1:0]  m_addr;
  logic           m_addr_first;
  logic           m_addr_last;
  logic           m_addr_valid;
  logic           m_addr_ready;
  logic           s_data_valid;
  logic           s_data_ready;
  logic           s_data_last;
  logic           busy;
  logic           done;
  logic           err;
  modport slave (
    input  cmd_base, cmd_len, cmd_ram_sel, cmd_mem_sel, cmd_channel, cmd_valid,
    input  m_addr_ready, s_data_valid, s_data_ready, s_data_last,
    output cmd_ready, info, m_addr, m_addr_first, m_addr_last, m_addr_valid,
    output busy, done, err
  );
  modport master (
    output cmd_base, cmd_len, cmd_ram_sel, cmd_mem_sel, cmd_channel, cmd_valid,
    output m_addr_ready, s_data_valid, s_data_ready, s_data_last,
    input  cmd_ready, info, m_addr, m_addr_first, m_addr_last, m_addr_valid,
    input  busy, done, err
  );
endinterface

// File: rtl/conv_rd_sched.sv
// conv_rd_sched: one-command-at-a-time read address sequencer that retires on the final consumed data beat
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : conv_rd_sched_if.slave (cmd in, info + address stream out, data monitor in, busy/done/err out)
module conv_rd_sched #(
  parameter int AW  = 13,
  parameter int LW  = 13,
  parameter int IFW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  conv_rd_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ADDR, DRAIN} state_t;
  state_t         r_state, w_next;
  logic [AW-1:0]  r_base;
  logic [LW-1:0]  r_len, r_addr_cnt, r_beat_cnt;
  logic [IFW-1:0] r_info;
  logic           r_last_seen, r_err, r_done;
  logic           w_accept, w_addr_hs, w_at_last, w_beat, w_last_beat, w_drain_exit;
  assign w_accept     = bus.cmd_valid && r_state == IDLE;
  assign w_addr_hs    = r_state == ADDR && bus.m_addr_ready;
  assign w_at_last    = r_addr_cnt == r_len;
  assign w_beat       = r_state != IDLE && bus.s_data_valid && bus.s_data_ready;
  assign w_last_beat  = w_beat && bus.s_data_last;
  // last may already have been consumed while addresses were still going out
  assign w_drain_exit = r_state == DRAIN && (w_last_beat || r_last_seen);
  assign bus.cmd_ready    = r_state == IDLE;
  assign bus.busy         = r_state != IDLE;
  assign bus.m_addr_valid = r_state == ADDR;
  assign bus.m_addr       = r_base + AW'(r_addr_cnt);
  assign bus.m_addr_first = r_state == ADDR && r_addr_cnt == '0;
  assign bus.m_addr_last  = r_state == ADDR && w_at_last;
  assign bus.info         = r_info;
  assign bus.done         = r_done;
  assign bus.err          = r_err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? ADDR : IDLE;
      ADDR:    w_next = (w_addr_hs && w_at_last) ? DRAIN : ADDR;
      DRAIN:   w_next = w_drain_exit ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_base      <= '0;
      r_len       <= '0;
      r_info      <= '0;
      r_addr_cnt  <= '0;
      r_beat_cnt  <= '0;
      r_last_seen <= 1'b0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_drain_exit;
      if (w_accept) begin
        r_base      <= bus.cmd_base;
        r_len       <= bus.cmd_len;
        r_info      <= IFW'({bus.cmd_ram_sel, bus.cmd_mem_sel, bus.cmd_channel});
        r_addr_cnt  <= '0;
        r_beat_cnt  <= '0;
        r_last_seen <= 1'b0;
        r_err       <= 1'b0;
      end else begin
        if (w_addr_hs) r_addr_cnt <= r_addr_cnt + LW'(1);
        if (w_beat) r_beat_cnt <= r_beat_cnt + LW'(1);
        if (w_last_beat) r_last_seen <= 1'b1;
        // beat_cnt is pre-increment here, so a correct burst has it equal to len on last
        if (w_last_beat && r_beat_cnt != r_len) r_err <= 1'b1;
      end
    end
endmodule

// File: tb/tb_conv_rd_sched.sv
// tb_conv_rd_sched: directed self-checking bench for conv_rd_sched
module tb_conv_rd_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  conv_rd_sched_if #(.AW(13), .LW(13), .IFW(5)) bus();
  conv_rd_sched #(.AW(13), .LW(13), .IFW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_cmd(input logic [12:0] base, input logic [12:0] len, input logic ram,
                          input logic mem, input logic [2:0] ch);
    check("cmd_ready", bus.cmd_ready, 1);
    bus.cmd_base    = base;
    bus.cmd_len     = len;
    bus.cmd_ram_sel = ram;
    bus.cmd_mem_sel = mem;
    bus.cmd_channel = ch;
    bus.cmd_valid   = 1'b1;
    tick();
    bus.cmd_valid   = 1'b0;
    check("busy_after_accept", bus.busy, 1);
    check("info_latched", bus.info, {ram, mem, ch});
    check("err_cleared", bus.err, 0);
  endtask
  task automatic addr_phase(input logic [12:0] base, input int len, input bit stall);
    int k = 0;
    for (int c = 0; c < 200 && k <= len; c++) begin
      logic        rdy;
      logic [12:0] ea;
      rdy = !stall || (c % 3 == 0);
      ea  = base + k[12:0];
      bus.m_addr_ready = rdy;
      check("addr_valid", bus.m_addr_valid, 1);
      check("addr", bus.m_addr, ea);
      check("addr_first", bus.m_addr_first, k == 0);
      check("addr_last", bus.m_addr_last, k == len);
      if (rdy) k++;
      tick();
    end
    bus.m_addr_ready = 1'b0;
    check("addr_handshakes", k, len + 1);
    check("addr_valid_drain", bus.m_addr_valid, 0);
  endtask
  task automatic beat(input logic last);
    bus.s_data_valid = 1'b1;
    bus.s_data_last  = last;
    tick();
    bus.s_data_valid = 1'b0;
    bus.s_data_last  = 1'b0;
  endtask
  task automatic expect_done(input logic e);
    check("done", bus.done, 1);
    check("busy_idle", bus.busy, 0);
    check("err", bus.err, e);
    tick();
    check("done_pulse_end", bus.done, 0);
    check("err_hold", bus.err, e);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.cmd_base = '0; bus.cmd_len = '0; bus.cmd_ram_sel = 0; bus.cmd_mem_sel = 0;
    bus.cmd_channel = '0; bus.cmd_valid = 0; bus.m_addr_ready = 0;
    bus.s_data_valid = 0; bus.s_data_ready = 1; bus.s_data_last = 0;
    tick();
    tick();
    check("rst_addr_valid", bus.m_addr_valid, 0);
    check("rst_addr", bus.m_addr, 0);
    check("rst_first", bus.m_addr_first, 0);
    check("rst_last", bus.m_addr_last, 0);
    check("rst_info", bus.info, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", bus.cmd_ready, 1);
    // single burst
    send_cmd(13'h010, 13'd3, 0, 0, 3'd0);
    addr_phase(13'h010, 3, 0);
    check("busy_drain", bus.busy, 1);
    check("info_drain", bus.info, 5'h00);
    beat(0); beat(0); beat(0);
    check("no_early_done", bus.done, 0);
    beat(1);
    expect_done(0);
    check("info_idle", bus.info, 5'h00);
    // backpressure
    send_cmd(13'h100, 13'd5, 1, 1, 3'd3);
    addr_phase(13'h100, 5, 1);
    for (int i = 0; i < 6; i++) beat(i == 5);
    expect_done(0);
    check("info_hold", bus.info, 5'h1B);
    // wrap
    send_cmd(13'h1FFE, 13'd3, 0, 1, 3'd7);
    check("wrap_first_addr", bus.m_addr, 13'h1FFE);
    addr_phase(13'h1FFE, 3, 0);
    for (int i = 0; i < 4; i++) beat(i == 3);
    expect_done(0);
    // early last while still in ADDR
    send_cmd(13'h020, 13'd1, 0, 0, 3'd2);
    bus.m_addr_ready = 1'b0;
    beat(0);
    beat(1);
    check("early_stall_valid", bus.m_addr_valid, 1);
    check("early_stall_addr", bus.m_addr, 13'h020);
    addr_phase(13'h020, 1, 0);
    check("early_drain_done", bus.done, 0);
    check("early_drain_busy", bus.busy, 1);
    tick();
    expect_done(0);
    // count mismatch
    send_cmd(13'h040, 13'd3, 0, 0, 3'd1);
    addr_phase(13'h040, 3, 0);
    beat(0);
    beat(1);
    expect_done(1);
    tick();
    check("err_sticky", bus.err, 1);
    // next accept clears err; then reset mid-burst
    send_cmd(13'h080, 13'd7, 1, 0, 3'd5);
    check("info_b2", bus.info, 5'h15);
    bus.m_addr_ready = 1'b1;
    tick();
    tick();
    bus.m_addr_ready = 1'b0;
    check("mid_addr", bus.m_addr, 13'h082);
    check("mid_valid", bus.m_addr_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus.m_addr_valid, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_info", bus.info, 0);
    check("arst_addr", bus.m_addr, 0);
    check("arst_first", bus.m_addr_first, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", bus.cmd_ready, 1);
    for (int i = 0; i < 5; i++) begin
      check("post_rst_no_done", bus.done, 0);
      check("post_rst_idle", bus.busy, 0);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
